// File: rtl/vga_monitor_pkg.sv
// vga_monitor_pkg: shared types and default geometry for the VGA monitor.
// Coordinates are 10 bits, wide enough for 640x480 plus saturation headroom.
package vga_monitor_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_FRAME  = 1'b1
    } state_t;

    localparam int unsigned H_ACTIVE_DEF   = 640;
    localparam int unsigned V_ACTIVE_DEF   = 480;
    localparam logic [7:0]  LIT_THRESH_DEF = 8'h80;
    localparam coord_t      COORD_MAX      = 10'h3FF;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: strobe-qualified edge detector for sync/blank lines.
// History only advances on pixel strobes, so the pulse is one strobe wide.
module vga_sync_edge #(
    parameter logic FALLING = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic level,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else if (enable) begin
            prev_q <= level;
        end
    end

    assign pulse = enable &&
                   (FALLING ? (prev_q && !level) : (!prev_q && level));

endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side checker for the board VGA stream.
// Recovers pixel coordinates, checks line/frame timing, boxes lit pixels.
module vga_frame_monitor
    import vga_monitor_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic [7:0]  LIT_THRESH = LIT_THRESH_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       iVGA_H_SYNC,
    input  logic       iVGA_V_SYNC,
    input  logic       iVGA_BLANK,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output coord_t     oCoord_X,
    output coord_t     oCoord_Y,
    output logic       oPixel_valid,
    output logic       oLocked,
    output logic       oFrame_done,
    output logic       oObject_found,
    output coord_t     oBox_X_min,
    output coord_t     oBox_X_max,
    output coord_t     oBox_Y_min,
    output coord_t     oBox_Y_max,
    output logic       oTiming_error
);

    state_t state_q, state_n;
    coord_t x_q, x_n, y_q, y_n;
    coord_t xmin_q, xmin_n, xmax_q, xmax_n;
    coord_t ymin_q, ymin_n, ymax_q, ymax_n;
    logic   found_q, found_n, err_q, err_n;
    logic   hs_fall, vs_fall, bl_fall;
    logic   lit, active, close, frame_err;

    vga_sync_edge #(.FALLING(1'b1)) u_hs_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .level  (iVGA_H_SYNC),
        .pulse  (hs_fall)
    );

    vga_sync_edge #(.FALLING(1'b1)) u_vs_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .level  (iVGA_V_SYNC),
        .pulse  (vs_fall)
    );

    vga_sync_edge #(.FALLING(1'b1)) u_bl_edge (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .level  (iVGA_BLANK),
        .pulse  (bl_fall)
    );

    assign lit = (iRed >= LIT_THRESH) &&
                 (iGreen >= LIT_THRESH) &&
                 (iBlue >= LIT_THRESH);

    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        xmin_n  = xmin_q;
        xmax_n  = xmax_q;
        ymin_n  = ymin_q;
        ymax_n  = ymax_q;
        found_n = found_q;
        err_n   = err_q;
        active  = 1'b0;
        close   = 1'b0;
        unique case (state_q)
            S_SEARCH: begin
                if (vs_fall) begin
                    state_n = S_FRAME;
                end
            end
            S_FRAME: begin
                active = enable && iVGA_BLANK;
                if (active) begin
                    if (x_q == COORD_MAX) begin
                        err_n = 1'b1;
                    end else begin
                        x_n = x_q + 1'b1;
                    end
                    if (lit) begin
                        found_n = 1'b1;
                        if (!found_q) begin
                            xmin_n = x_q;
                            xmax_n = x_q;
                            ymin_n = y_q;
                            ymax_n = y_q;
                        end else begin
                            if (x_q < xmin_q) xmin_n = x_q;
                            if (x_q > xmax_q) xmax_n = x_q;
                            if (y_q < ymin_q) ymin_n = y_q;
                            if (y_q > ymax_q) ymax_n = y_q;
                        end
                    end
                end
                // Line-end check sees x before any same-strobe hsync clear.
                if (bl_fall) begin
                    if (x_q != coord_t'(H_ACTIVE)) err_n = 1'b1;
                    if (y_q == COORD_MAX) begin
                        err_n = 1'b1;
                    end else begin
                        y_n = y_q + 1'b1;
                    end
                    x_n = '0;
                end
                if (hs_fall) begin
                    x_n = '0;
                end
                close = vs_fall;
            end
            default: begin
                state_n = S_SEARCH;
            end
        endcase
    end

    assign frame_err = err_n || (y_n != coord_t'(V_ACTIVE));
    assign oLocked   = (state_q == S_FRAME);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_SEARCH;
            x_q           <= '0;
            y_q           <= '0;
            xmin_q        <= '0;
            xmax_q        <= '0;
            ymin_q        <= '0;
            ymax_q        <= '0;
            found_q       <= 1'b0;
            err_q         <= 1'b0;
            oCoord_X      <= '0;
            oCoord_Y      <= '0;
            oPixel_valid  <= 1'b0;
            oFrame_done   <= 1'b0;
            oObject_found <= 1'b0;
            oBox_X_min    <= '0;
            oBox_X_max    <= '0;
            oBox_Y_min    <= '0;
            oBox_Y_max    <= '0;
            oTiming_error <= 1'b0;
        end else begin
            state_q      <= state_n;
            oPixel_valid <= active;
            oFrame_done  <= close;
            if (active) begin
                oCoord_X <= x_q;
                oCoord_Y <= y_q;
            end
            if (close) begin
                oObject_found <= found_n;
                oBox_X_min    <= xmin_n;
                oBox_X_max    <= xmax_n;
                oBox_Y_min    <= ymin_n;
                oBox_Y_max    <= ymax_n;
                oTiming_error <= frame_err;
                x_q           <= '0;
                y_q           <= '0;
                xmin_q        <= '0;
                xmax_q        <= '0;
                ymin_q        <= '0;
                ymax_q        <= '0;
                found_q       <= 1'b0;
                err_q         <= 1'b0;
            end else begin
                x_q     <= x_n;
                y_q     <= y_n;
                xmin_q  <= xmin_n;
                xmax_q  <= xmax_n;
                ymin_q  <= ymin_n;
                ymax_q  <= ymax_n;
                found_q <= found_n;
                err_q   <= err_n;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: directed frame sequence with random pixel content,
// scaled-down geometry, results compared against a frame-level model.
module tb_vga_frame_monitor;
    import vga_monitor_pkg::*;

    localparam int HA = 32;
    localparam int VA = 24;
    localparam int HMAX = HA + 2;
    localparam int VMAX = VA + 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int HFP = 2;
    localparam int VSL = 2;
    localparam int VBP = 3;
    localparam int VFP = 2;
    localparam logic [7:0] THR = 8'h80;

    localparam int K_RAND   = 0;
    localparam int K_GOLD   = 1;
    localparam int K_BLACK  = 2;
    localparam int K_CORNER = 3;
    localparam int K_SHORTL = 4;
    localparam int K_SHORTF = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       hs, vs, blank;
    logic [7:0] red, grn, blu;
    coord_t     cx, cy, bx0, bx1, by0, by1;
    logic       pv, locked, fdone, found, terr;

    vga_frame_monitor #(
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .LIT_THRESH (THR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .iVGA_H_SYNC   (hs),
        .iVGA_V_SYNC   (vs),
        .iVGA_BLANK    (blank),
        .iRed          (red),
        .iGreen        (grn),
        .iBlue         (blu),
        .oCoord_X      (cx),
        .oCoord_Y      (cy),
        .oPixel_valid  (pv),
        .oLocked       (locked),
        .oFrame_done   (fdone),
        .oObject_found (found),
        .oBox_X_min    (bx0),
        .oBox_X_max    (bx1),
        .oBox_Y_min    (by0),
        .oBox_Y_max    (by1),
        .oTiming_error (terr)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [7:0] pr [VMAX][HMAX];
    logic [7:0] pg [VMAX][HMAX];
    logic [7:0] pb [VMAX][HMAX];
    int wid [VMAX];
    int nlines;

    logic   e_found, e_err;
    int     e_x0, e_x1, e_y0, e_y1;

    int     done_cnt = 0;
    int     bad_gate = 0;
    logic   en_seen = 1'b0;
    logic   c_found, c_err;
    coord_t c_x0, c_x1, c_y0, c_y1;
    int     pix_x [$];
    int     pix_y [$];

    always @(posedge clock) en_seen <= enable;

    always @(negedge clock) begin
        if ((pv || fdone) && !en_seen) bad_gate++;
        if (fdone) begin
            done_cnt++;
            c_found = found;
            c_err   = terr;
            c_x0    = bx0;
            c_x1    = bx1;
            c_y0    = by0;
            c_y1    = by1;
        end
        if (pv) begin
            pix_x.push_back(int'(cx));
            pix_y.push_back(int'(cy));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [7:0] hi8();
        case ($urandom_range(0, 2))
            0: return 8'h80;
            1: return 8'hFF;
            default: return 8'($urandom_range(128, 255));
        endcase
    endfunction

    task automatic strobe(input logic h, input logic v, input logic bl,
                          input logic [7:0] rr, input logic [7:0] gg,
                          input logic [7:0] bb);
        @(negedge clock);
        hs = h; vs = v; blank = bl;
        red = rr; grn = gg; blu = bb;
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        blank = 1'($urandom_range(0, 1));
        red = rnd8(); grn = rnd8(); blu = rnd8();
        if ($urandom_range(0, 7) == 0) @(negedge clock);
    endtask

    task automatic drive_line(input logic v, input int row, input bit act);
        int w;
        w = act ? wid[row] : HA;
        for (int i = 0; i < HSW; i++)
            strobe(1'b0, v, 1'b0, rnd8(), rnd8(), rnd8());
        for (int i = 0; i < HBP; i++)
            strobe(1'b1, v, 1'b0, rnd8(), rnd8(), rnd8());
        for (int i = 0; i < w; i++) begin
            if (act) strobe(1'b1, v, 1'b1, pr[row][i], pg[row][i], pb[row][i]);
            else     strobe(1'b1, v, 1'b0, rnd8(), rnd8(), rnd8());
        end
        for (int i = 0; i < HFP; i++)
            strobe(1'b1, v, 1'b0, rnd8(), rnd8(), rnd8());
    endtask

    task automatic drive_rows(input int y0, input int y1);
        for (int y = y0; y < y1; y++) drive_line(1'b1, y, 1'b1);
    endtask

    task automatic front_porch();
        for (int i = 0; i < VFP; i++) drive_line(1'b1, 0, 1'b0);
    endtask

    task automatic set_px(input int y, input int x, input logic [7:0] rr,
                          input logic [7:0] gg, input logic [7:0] bb);
        pr[y][x] = rr; pg[y][x] = gg; pb[y][x] = bb;
    endtask

    task automatic fill(input int kind);
        int ch;
        nlines = VA;
        for (int y = 0; y < VMAX; y++) begin
            wid[y] = HA;
            for (int x = 0; x < HMAX; x++) begin
                if (kind == K_GOLD || kind == K_BLACK || kind == K_CORNER) begin
                    set_px(y, x, 8'h00, 8'h00, 8'h00);
                end else if ($urandom_range(0, 63) == 0) begin
                    set_px(y, x, hi8(), hi8(), hi8());
                end else begin
                    set_px(y, x, rnd8(), rnd8(), rnd8());
                    ch = $urandom_range(0, 2);
                    if (ch == 0) pr[y][x] = 8'($urandom_range(0, 127));
                    if (ch == 1) pg[y][x] = 8'($urandom_range(0, 127));
                    if (ch == 2) pb[y][x] = 8'($urandom_range(0, 127));
                end
            end
        end
        // Golden square scaled to this geometry: cols 10..17, rows 8..13.
        if (kind == K_GOLD)
            for (int y = 8; y <= 13; y++)
                for (int x = 10; x <= 17; x++)
                    set_px(y, x, 8'hFF, 8'hFF, 8'hFF);
        if (kind == K_CORNER) begin
            set_px(0, 0, 8'hFF, 8'hFF, 8'hFF);
            set_px(VA - 1, HA - 1, 8'hFF, 8'hFF, 8'hFF);
        end
        if (kind == K_SHORTL) wid[$urandom_range(0, VA - 1)] = HA - 1;
        if (kind == K_SHORTF) nlines = VA - 1;
    endtask

    task automatic model();
        bit l;
        e_found = 1'b0;
        e_err = (nlines != VA);
        e_x0 = 0; e_x1 = 0; e_y0 = 0; e_y1 = 0;
        for (int y = 0; y < nlines; y++) begin
            if (wid[y] != HA) e_err = 1'b1;
            for (int x = 0; x < wid[y]; x++) begin
                l = pr[y][x] >= THR && pg[y][x] >= THR && pb[y][x] >= THR;
                if (l && !e_found) begin
                    e_x0 = x; e_x1 = x; e_y0 = y; e_y1 = y;
                end else if (l) begin
                    e_x0 = (x < e_x0) ? x : e_x0;
                    e_x1 = (x > e_x1) ? x : e_x1;
                    e_y0 = (y < e_y0) ? y : e_y0;
                    e_y1 = (y > e_y1) ? y : e_y1;
                end
                if (l) e_found = 1'b1;
            end
        end
    endtask

    task automatic run_frame(input int kind);
        int start, k, bad, cnt;
        fill(kind);
        model();
        start = pix_x.size();
        drive_rows(0, nlines);
        front_porch();
        k = start; bad = 0; cnt = 0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < wid[y]; x++) begin
                if (k >= pix_x.size()) bad++;
                else if (pix_x[k] != x || pix_y[k] != y) bad++;
                k++;
                cnt++;
            end
        end
        check("pix_count", pix_x.size() - start, cnt);
        check("pix_coords", bad, 0);
    endtask

    task automatic vsync_and_check(input bit expect_report);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < VSL; i++) drive_line(1'b0, 0, 1'b0);
        for (int i = 0; i < VBP; i++) drive_line(1'b1, 0, 1'b0);
        check("locked", locked, 1);
        if (expect_report) begin
            check("done_once", done_cnt - d0, 1);
            check("found", c_found, e_found);
            check("box_x_min", c_x0, e_x0);
            check("box_x_max", c_x1, e_x1);
            check("box_y_min", c_y0, e_y0);
            check("box_y_max", c_y1, e_y1);
            check("timing_err", c_err, e_err);
        end else begin
            check("no_report", done_cnt - d0, 0);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_terr"}, terr, 0);
        check({tag, "_box"}, {bx0, bx1, by0[1:0]}, 0);
        check({tag, "_ymm"}, {by0, by1}, 0);
        check({tag, "_coord"}, {cx, cy}, 0);
        check({tag, "_pulses"}, {pv, fdone}, 0);
    endtask

    initial begin
        int pstart;
        reset = 1'b1; enable = 1'b0;
        hs = 1'b1; vs = 1'b1; blank = 1'b0;
        red = 8'h00; grn = 8'h00; blu = 8'h00;
        repeat (4) @(negedge clock);
        check_cleared("reset");
        reset = 1'b0;

        // Stream picked up mid-frame: nothing may be stamped or reported.
        fill(K_RAND);
        pstart = pix_x.size();
        drive_rows(VA / 2, VA);
        front_porch();
        check("search_locked", locked, 0);
        check("search_pixels", pix_x.size() - pstart, 0);
        vsync_and_check(1'b0);
        check("first_done_cnt", done_cnt, 0);

        run_frame(K_GOLD);   vsync_and_check(1'b1);
        run_frame(K_BLACK);  vsync_and_check(1'b1);
        run_frame(K_CORNER); vsync_and_check(1'b1);
        for (int i = 0; i < 3; i++) begin
            run_frame(K_RAND); vsync_and_check(1'b1);
        end
        run_frame(K_SHORTL); vsync_and_check(1'b1);
        run_frame(K_RAND);   vsync_and_check(1'b1);
        run_frame(K_SHORTF); vsync_and_check(1'b1);
        run_frame(K_RAND);   vsync_and_check(1'b1);

        // Reset a third of the way down a golden frame.
        fill(K_GOLD);
        drive_rows(0, VA / 3);
        @(negedge clock);
        reset = 1'b1; enable = 1'b0;
        hs = 1'b1; vs = 1'b1; blank = 1'b0;
        repeat (2) @(negedge clock);
        check_cleared("midreset");
        reset = 1'b0;
        drive_rows(VA / 3, VA);
        front_porch();
        check("post_reset_locked", locked, 0);
        vsync_and_check(1'b0);
        run_frame(K_GOLD);
        vsync_and_check(1'b1);

        check("enable_gating", bad_gate, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
